bip2_control_unit: RTL and testbench

Multi-cycle control unit for the BIP2 accumulator processor. It fetches 16-bit instructions from program memory, holds them in an instruction register and owns the program counter. It decodes each instruction into the datapath control word (accumulator/status write enables, A/B operand selects, ALU op, data-memory strobes). The block sits directly upstream of the BIP2 datapath: it drives that datapath's operand and control inputs and consumes its Z/N status flags.

---
 rtl/bip2_control_unit.sv | 169 ++++++++++++++++
 tb/tb_bip2_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip2_control_unit.sv
// BIP2 multi-cycle control unit: fetches instructions, owns the PC and IR,
// and decodes each instruction into the datapath control word.
module bip2_control_unit #(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic [DATA_WIDTH-1:0]    prog_data_in,
    output logic [OPERAND_WIDTH-1:0] prog_addr_out,
    output logic                     prog_rd_out,
    input  logic                     status_Z_in,
    input  logic                     status_N_in,
    output logic [OPERAND_WIDTH-1:0] operand_out,
    output logic [1:0]               sel_A_out,
    output logic                     sel_B_out,
    output logic                     alu_op_out,
    output logic                     acc_wr_out,
    output logic                     status_wr_out,
    output logic                     acc_reset_out,
    output logic                     status_reset_out,
    output logic                     data_rd_out,
    output logic                     data_wr_out,
    output logic [OPERAND_WIDTH-1:0] pc_out,
    output logic                     halted_out
);

    localparam int OPCODE_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_HLT  = OPCODE_WIDTH'(0),
        OP_STO  = OPCODE_WIDTH'(1),
        OP_LD   = OPCODE_WIDTH'(2),
        OP_LDI  = OPCODE_WIDTH'(3),
        OP_ADD  = OPCODE_WIDTH'(4),
        OP_ADDI = OPCODE_WIDTH'(5),
        OP_SUB  = OPCODE_WIDTH'(6),
        OP_SUBI = OPCODE_WIDTH'(7),
        OP_BEQ  = OPCODE_WIDTH'(8),
        OP_BNE  = OPCODE_WIDTH'(9),
        OP_BGT  = OPCODE_WIDTH'(10),
        OP_BGE  = OPCODE_WIDTH'(11),
        OP_BLT  = OPCODE_WIDTH'(12),
        OP_BLE  = OPCODE_WIDTH'(13),
        OP_JMP  = OPCODE_WIDTH'(14)
    } opcode_t;

    state_t                  state;
    logic [OPERAND_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    ir;
    opcode_t                  ir_op;
    opcode_t                  fetch_op;
    logic [OPERAND_WIDTH-1:0] ir_operand;
    logic                     needs_mem;
    logic                     taken;

    assign ir_op      = opcode_t'(ir[DATA_WIDTH-1:OPERAND_WIDTH]);
    assign fetch_op   = opcode_t'(prog_data_in[DATA_WIDTH-1:OPERAND_WIDTH]);
    assign ir_operand = ir[OPERAND_WIDTH-1:0];

    // Memory-phase decision is taken from the word arriving this cycle, not the IR.
    always_comb begin
        needs_mem = 1'b0;
        case (fetch_op)
            OP_LD, OP_ADD, OP_SUB: needs_mem = 1'b1;
            default:               needs_mem = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (ir_op)
            OP_BEQ:  taken = status_Z_in;
            OP_BNE:  taken = ~status_Z_in;
            OP_BGT:  taken = ~status_Z_in & ~status_N_in;
            OP_BGE:  taken = ~status_N_in;
            OP_BLT:  taken = status_N_in;
            OP_BLE:  taken = status_Z_in | status_N_in;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= prog_data_in;
                    state <= needs_mem ? S_MEM : S_EXEC;
                end
                S_MEM:    state <= S_EXEC;
                S_EXEC: begin
                    if (ir_op == OP_HLT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                        pc    <= taken ? ir_operand : pc + OPERAND_WIDTH'(1);
                    end
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    assign prog_addr_out = pc;
    assign pc_out        = pc;
    assign operand_out   = ir_operand;

    // Strobes decode from the state register so an asynchronous reset
    // removes them within the same cycle.
    always_comb begin
        prog_rd_out      = 1'b0;
        data_rd_out      = 1'b0;
        data_wr_out      = 1'b0;
        acc_wr_out       = 1'b0;
        status_wr_out    = 1'b0;
        acc_reset_out    = 1'b0;
        status_reset_out = 1'b0;
        sel_A_out        = 2'b00;
        sel_B_out        = 1'b0;
        alu_op_out       = 1'b0;
        halted_out       = 1'b0;
        case (state)
            S_INIT: begin
                acc_reset_out    = 1'b1;
                status_reset_out = 1'b1;
            end
            S_FETCH: prog_rd_out = 1'b1;
            S_MEM:   data_rd_out = 1'b1;
            S_EXEC: begin
                case (ir_op)
                    OP_STO: data_wr_out = 1'b1;
                    OP_LD:  acc_wr_out  = 1'b1;
                    OP_LDI: begin
                        sel_A_out  = 2'b01;
                        acc_wr_out = 1'b1;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        sel_A_out     = 2'b10;
                        sel_B_out     = (ir_op == OP_ADDI) || (ir_op == OP_SUBI);
                        alu_op_out    = (ir_op == OP_SUB) || (ir_op == OP_SUBI);
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:  halted_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Bench for bip2_control_unit: an instruction-level model of the BIP2 machine
// predicts every cycle's control word; the bench also plays program memory and datapath.
module tb_bip2_control_unit;

    localparam logic [4:0] O_HLT = 5'd0,  O_STO = 5'd1,  O_LD = 5'd2,   O_LDI = 5'd3;
    localparam logic [4:0] O_ADD = 5'd4,  O_ADDI = 5'd5, O_SUB = 5'd6,  O_SUBI = 5'd7;
    localparam logic [4:0] O_BEQ = 5'd8,  O_BNE = 5'd9,  O_BGT = 5'd10, O_BGE = 5'd11;
    localparam logic [4:0] O_BLT = 5'd12, O_BLE = 5'd13, O_JMP = 5'd14, O_NOP = 5'd15;

    logic        clock_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic [15:0] prog_data_in;
    logic [10:0] prog_addr_out;
    logic        prog_rd_out;
    logic        status_Z_in = 1'b0;
    logic        status_N_in = 1'b0;
    logic [10:0] operand_out;
    logic [1:0]  sel_A_out;
    logic        sel_B_out, alu_op_out, acc_wr_out, status_wr_out;
    logic        acc_reset_out, status_reset_out, data_rd_out, data_wr_out;
    logic [10:0] pc_out;
    logic        halted_out;

    bip2_control_unit #(.DATA_WIDTH(16), .OPERAND_WIDTH(11)) dut (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .prog_data_in(prog_data_in),
        .prog_addr_out(prog_addr_out), .prog_rd_out(prog_rd_out),
        .status_Z_in(status_Z_in), .status_N_in(status_N_in), .operand_out(operand_out),
        .sel_A_out(sel_A_out), .sel_B_out(sel_B_out), .alu_op_out(alu_op_out),
        .acc_wr_out(acc_wr_out), .status_wr_out(status_wr_out),
        .acc_reset_out(acc_reset_out), .status_reset_out(status_reset_out),
        .data_rd_out(data_rd_out), .data_wr_out(data_wr_out),
        .pc_out(pc_out), .halted_out(halted_out)
    );

    always #5 clock_in = ~clock_in;

    logic [15:0] pmem [2048];
    logic [15:0] dmem [2048];

    // Program memory: data valid the cycle after a read strobe, junk otherwise.
    always @(posedge clock_in)
        prog_data_in <= prog_rd_out ? pmem[prog_addr_out] : 16'($urandom);

    int vectors = 0;
    int fails   = 0;

    // Instruction-level machine state.
    logic [10:0] mpc;
    logic [15:0] mir;
    logic [15:0] acc;
    bit          mz, mn;
    int          cyc;
    bit          halted;

    // Observations taken from the DUT for the literal checks.
    int          wr_cycle;
    logic [10:0] wr_opnd;
    logic [1:0]  swr_aluop;
    logic [2:0]  awr_sel;
    int          rd_count;

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] a);
        return {op, a};
    endfunction

    // Control word order: prog_rd, data_rd, data_wr, acc_wr, status_wr,
    // acc_reset, status_reset, halted, sel_A[1:0], sel_B, alu_op.
    function automatic logic [11:0] ctl(input bit prd, input bit drd, input bit dwr,
                                        input bit awr, input bit swr, input bit rst,
                                        input bit hlt, input logic [1:0] sa,
                                        input bit sb, input bit aop);
        return {prd, drd, dwr, awr, swr, rst, rst, hlt, sa, sb, aop};
    endfunction

    task automatic check(input string name, input logic [11:0] exp_ctl,
                         input logic [10:0] exp_pc, input logic [10:0] exp_opnd);
        logic [11:0] act;
        act = {prog_rd_out, data_rd_out, data_wr_out, acc_wr_out, status_wr_out,
               acc_reset_out, status_reset_out, halted_out, sel_A_out, sel_B_out, alu_op_out};
        vectors++;
        if (act !== exp_ctl || pc_out !== exp_pc || prog_addr_out !== exp_pc ||
            operand_out !== exp_opnd) begin
            fails++;
            $display("FAIL %s @%0t: ctl=%b pc=%0d addr=%0d opnd=%0d, expected ctl=%b pc=%0d opnd=%0d",
                     name, $time, act, pc_out, prog_addr_out, operand_out,
                     exp_ctl, exp_pc, exp_opnd);
        end
        if (data_wr_out === 1'b1) begin
            wr_cycle = cyc;
            wr_opnd  = operand_out;
        end
        if (status_wr_out === 1'b1) swr_aluop = {status_wr_out, alu_op_out};
        if (acc_wr_out === 1'b1) awr_sel = {sel_A_out, sel_B_out};
        if (data_rd_out === 1'b1) rd_count++;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle_begin();
        @(posedge clock_in);
        #1;
        status_Z_in = mz;
        status_N_in = mn;
        cyc++;
    endtask

    task automatic model_reset();
        mpc = '0; mir = '0; acc = '0; mz = 1'b0; mn = 1'b0;
        halted = 1'b0; wr_cycle = -1; wr_opnd = '0; swr_aluop = '0; awr_sel = '0;
        rd_count = 0;
    endtask

    // Leaves the DUT in its INIT cycle, cycle counter at 0.
    task automatic do_reset();
        reset_n_in = 1'b0;
        model_reset();
        cycle_begin();
        cycle_begin();
        check("in reset", ctl(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 11'd0, 11'd0);
        reset_n_in = 1'b1;
        cyc = 0;
        check("init", ctl(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 11'd0, 11'd0);
    endtask

    task automatic run(input int max_instr);
        logic [15:0] instr, b;
        logic [4:0]  op;
        logic [10:0] opd;
        bit          dwr, awr, swr, sb, aop, tk;
        logic [1:0]  sa;
        for (int k = 0; k < max_instr; k++) begin
            instr = pmem[mpc];
            op    = instr[15:11];
            opd   = instr[10:0];
            cycle_begin();
            check("fetch", ctl(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), mpc, mir[10:0]);
            cycle_begin();
            check("decode", ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), mpc, mir[10:0]);
            mir = instr;
            if (op == O_LD || op == O_ADD || op == O_SUB) begin
                cycle_begin();
                check("mem", ctl(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), mpc, opd);
            end
            dwr = 0; awr = 0; swr = 0; sb = 0; aop = 0; sa = 2'b00; tk = 0;
            case (op)
                O_STO: dwr = 1;
                O_LD:  awr = 1;
                O_LDI: begin awr = 1; sa = 2'b01; end
                O_ADD, O_ADDI, O_SUB, O_SUBI: begin
                    awr = 1; swr = 1; sa = 2'b10;
                    sb  = (op == O_ADDI) || (op == O_SUBI);
                    aop = (op == O_SUB)  || (op == O_SUBI);
                end
                O_BEQ: tk = mz;
                O_BNE: tk = !mz;
                O_BGT: tk = !mz && !mn;
                O_BGE: tk = !mn;
                O_BLT: tk = mn;
                O_BLE: tk = mz || mn;
                O_JMP: tk = 1;
                default: ;
            endcase
            cycle_begin();
            check("exec", ctl(0, 0, dwr, awr, swr, 0, 0, sa, sb, aop), mpc, opd);
            b = sb ? {5'b0, opd} : dmem[opd];
            case (op)
                O_STO: dmem[opd] = acc;
                O_LD:  acc = dmem[opd];
                O_LDI: acc = {5'b0, opd};
                O_ADD, O_ADDI, O_SUB, O_SUBI: begin
                    acc = aop ? acc - b : acc + b;
                    mz  = (acc == 16'd0);
                    mn  = acc[15];
                end
                default: ;
            endcase
            if (op == O_HLT) begin
                halted = 1'b1;
                return;
            end
            mpc = tk ? opd : mpc + 11'd1;
        end
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            check("halt", ctl(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), mpc, mir[10:0]);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) begin
            pmem[i] = ins(O_NOP, 11'd0);
            dmem[i] = '0;
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();

        // LDI 5; ADDI 3; STO 10; HLT
        clear_mem();
        pmem[0] = ins(O_LDI, 11'd5); pmem[1] = ins(O_ADDI, 11'd3);
        pmem[2] = ins(O_STO, 11'd10); pmem[3] = ins(O_HLT, 11'd0);
        do_reset();
        run(10);
        check_halt(4);
        check_val("sto cycle", wr_cycle, 9);
        check_val("sto operand", wr_opnd, 10);
        check_val("halted held", halted_out, 1);
        check_val("halt pc", pc_out, 3);
        check_val("model acc", acc, 8);
        check_val("model stored", dmem[10], 8);

        // LDI 1; SUBI 1; BEQ 20 -> taken
        clear_mem();
        pmem[0] = ins(O_LDI, 11'd1); pmem[1] = ins(O_SUBI, 11'd1);
        pmem[2] = ins(O_BEQ, 11'd20); pmem[3] = ins(O_HLT, 11'd0);
        pmem[20] = ins(O_HLT, 11'd0);
        do_reset();
        run(3);
        cycle_begin();
        check_val("beq taken addr", prog_addr_out, 20);
        check_val("subi status/aluop", swr_aluop, 2'b11);

        // Same with acc = 2 -> not taken
        pmem[0] = ins(O_LDI, 11'd2);
        do_reset();
        run(3);
        cycle_begin();
        check_val("beq fallthrough addr", prog_addr_out, 3);

        // LD 7; ADD 7; HLT
        clear_mem();
        dmem[7] = 16'd4;
        pmem[0] = ins(O_LD, 11'd7); pmem[1] = ins(O_ADD, 11'd7); pmem[2] = ins(O_HLT, 11'd0);
        do_reset();
        run(5);
        check_val("ld/add/hlt cycles", cyc, 11);
        check_val("mem reads", rd_count, 2);
        check_val("add selects", awr_sel, 3'b100);
        check_val("model acc ld/add", acc, 8);
        check_halt(2);

        // JMP 2047; NOP at 2047 wraps to 0
        clear_mem();
        pmem[0] = ins(O_JMP, 11'd2047);
        do_reset();
        run(1);
        cycle_begin();
        check_val("jmp 2047 addr", prog_addr_out, 2047);
        do_reset();
        run(2);
        cycle_begin();
        check_val("pc wrap addr", prog_addr_out, 0);

        // Reset asserted during the EXEC of STO
        clear_mem();
        pmem[0] = ins(O_LDI, 11'd9); pmem[1] = ins(O_STO, 11'd5);
        do_reset();
        run(1);
        cycle_begin();
        cycle_begin();
        cycle_begin();
        check_val("sto strobe before reset", data_wr_out, 1);
        #1 reset_n_in = 1'b0;
        #1;
        check_val("wr drops on reset", data_wr_out, 0);
        model_reset();
        check("reset in exec", ctl(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 11'd0, 11'd0);
        cycle_begin();
        reset_n_in = 1'b1;
        cyc = 0;
        check("init after reset", ctl(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 11'd0, 11'd0);
        cycle_begin();
        check("fetch after reset", ctl(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 11'd0, 11'd0);

        // Random programs over the whole opcode space
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 2048; i++) begin
                logic [4:0] op;
                op = ($urandom_range(0, 99) < 3) ? O_HLT : 5'($urandom_range(1, 31));
                pmem[i] = ins(op, 11'($urandom));
                dmem[i] = 16'($urandom);
            end
            do_reset();
            run(40);
            if (halted) check_halt(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
